// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcode/state encodings, the illegal-op marker value
//                and opcode classification helpers for alu_mdu.
//                Macro ALU_MDU_DIV_EN enables the divide opcodes.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // 5-bit opcode space; anything not listed here is illegal
    typedef enum logic [4:0] {
        OP_ADD    = 5'b00000,
        OP_SLL    = 5'b00001,
        OP_SLT    = 5'b00010,
        OP_SLTU   = 5'b00011,
        OP_XOR    = 5'b00100,
        OP_SRL    = 5'b00101,
        OP_OR     = 5'b00110,
        OP_AND    = 5'b00111,
        OP_SUB    = 5'b01001,
        OP_SRA    = 5'b01101,
        OP_MUL    = 5'b10000,
        OP_MULH   = 5'b10001,
        OP_MULHSU = 5'b10010,
        OP_MULHU  = 5'b10011,
        OP_DIV    = 5'b10100,
        OP_DIVU   = 5'b10101,
        OP_REM    = 5'b10110,
        OP_REMU   = 5'b10111
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } alu_state_e;

    // Result returned for illegal opcodes (zero-extended to WIDTH)
    localparam logic [15:0] ALU_MAGIC = 16'hDEAA;

    // Divide family: 101xx
    function automatic logic is_div_op(input logic [4:0] op);
        return (op[4:2] == 3'b101);
    endfunction

    // Opcodes that take the iterative path; divides only when compiled in
    function automatic logic is_mdu_op(input logic [4:0] op);
`ifdef ALU_MDU_DIV_EN
        return (op[4:3] == 2'b10);
`else
        return (op[4:2] == 3'b100);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module      : mdu_iter
//  Description : Iterative RV32M-style multiply/divide core. Works on operand
//                magnitudes (shift-add multiply, restoring divide), one step
//                per cycle for WIDTH cycles, then applies sign correction
//                combinationally on the held registers.
//                Macro ALU_MDU_DIV_EN compiles in the divider datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             done,
    output logic [WIDTH-1:0] res
);
    import alu_pkg::*;

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic                 r_run;
    logic [CNT_W-1:0]     r_count;
    logic [4:0]           r_op;
    logic                 r_neg_a;
    logic                 r_neg_b;
    logic [2*WIDTH-1:0]   r_prod;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplr;

    logic                 w_sgn_a;
    logic                 w_sgn_b;
    logic                 w_neg_a;
    logic                 w_neg_b;
    logic [WIDTH-1:0]     w_mag_a;
    logic [WIDTH-1:0]     w_mag_b;
    logic [2*WIDTH-1:0]   w_prod_s;

    // Which operands are interpreted as signed for this opcode
    always_comb begin
        w_sgn_a = 1'b0;
        w_sgn_b = 1'b0;
        case (op)
            OP_MULH:        begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            OP_MULHSU:      w_sgn_a = 1'b1;
            OP_DIV, OP_REM: begin w_sgn_a = 1'b1; w_sgn_b = 1'b1; end
            default:        ;
        endcase
    end

    assign w_neg_a = w_sgn_a & op1[WIDTH-1];
    assign w_neg_b = w_sgn_b & op2[WIDTH-1];
    assign w_mag_a = w_neg_a ? -op1 : op1;
    assign w_mag_b = w_neg_b ? -op2 : op2;

    // done is high during the cycle that performs the last iteration
    assign done = r_run && (r_count == c_last);

    // Iteration control: latch op and operand signs on start, count WIDTH steps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run   <= 1'b0;
            r_count <= '0;
            r_op    <= '0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
        end else if (start) begin
            r_run   <= 1'b1;
            r_count <= '0;
            r_op    <= op;
            r_neg_a <= w_neg_a;
            r_neg_b <= w_neg_b;
        end else if (r_run) begin
            r_count <= r_count + c_one;
            if (r_count == c_last) begin
                r_run <= 1'b0;
            end
        end
    end

    // Shift-add multiplier on magnitudes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod  <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
        end else if (start) begin
            r_prod  <= '0;
            r_mcand <= {{WIDTH{1'b0}}, w_mag_a};
            r_mplr  <= w_mag_b;
        end else if (r_run) begin
            if (r_mplr[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand <= {r_mcand[2*WIDTH-2:0], 1'b0};
            r_mplr  <= {1'b0, r_mplr[WIDTH-1:1]};
        end
    end

    assign w_prod_s = (r_neg_a ^ r_neg_b) ? -r_prod : r_prod;

`ifdef ALU_MDU_DIV_EN
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_dvsr;
    logic [WIDTH:0]   w_trial;

    // Bring down the next dividend bit and try to subtract the divisor;
    // the top bit of the difference flags a negative (restore) result
    assign w_trial = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvsr};

    // Restoring divider on magnitudes, one quotient bit per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quo  <= '0;
            r_rem  <= '0;
            r_dvsr <= '0;
        end else if (start) begin
            r_quo  <= w_mag_a;
            r_rem  <= '0;
            r_dvsr <= w_mag_b;
        end else if (r_run) begin
            if (!w_trial[WIDTH]) begin
                r_rem <= w_trial[WIDTH-1:0];
                r_quo <= {r_quo[WIDTH-2:0], 1'b1};
            end else begin
                r_rem <= {r_rem[WIDTH-2:0], r_quo[WIDTH-1]};
                r_quo <= {r_quo[WIDTH-2:0], 1'b0};
            end
        end
    end
`endif

    // Sign fix-up and selection of high/low product, quotient or remainder
    always_comb begin
        res = w_prod_s[WIDTH-1:0];
        case (r_op)
            OP_MULH, OP_MULHSU, OP_MULHU: res = w_prod_s[2*WIDTH-1:WIDTH];
`ifdef ALU_MDU_DIV_EN
            // Quotient negative when signs differ; remainder follows dividend
            OP_DIV, OP_DIVU: res = (r_neg_a ^ r_neg_b) ? -r_quo : r_quo;
            OP_REM, OP_REMU: res = r_neg_a ? -r_rem : r_rem;
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mdu
//  Description : Handshaked execute-stage ALU with registered result and an
//                iterative multiply/divide unit. Base ops complete in one
//                cycle; M ops take WIDTH+2 cycles from accept to out_valid.
//                Macro ALU_MDU_DIV_EN enables div/divu/rem/remu; without it
//                those opcodes return ALU_MAGIC like any illegal opcode.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);
    import alu_pkg::*;

    localparam logic [WIDTH-1:0] c_magic = WIDTH'(ALU_MAGIC);

    alu_state_e        r_state;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_out_valid;
    logic              r_in_ready;
    logic              r_busy;

    logic              w_accept;
    logic              w_div_zero;
    logic              w_to_calc;
    logic [SHW-1:0]    w_shamt;
    logic [WIDTH-1:0]  w_base;
    logic              w_mdu_done;
    logic [WIDTH-1:0]  w_mdu_res;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_shamt  = op2[SHW-1:0];

`ifdef ALU_MDU_DIV_EN
    // Divide by zero has a fixed answer, so it skips the iterations
    assign w_div_zero = is_div_op(op) && (op2 == '0);
`else
    assign w_div_zero = 1'b0;
`endif

    assign w_to_calc = w_accept && is_mdu_op(op) && !w_div_zero;

    // Single-cycle results: base ops, divide-by-zero specials, illegal ops
    always_comb begin
        w_base = c_magic;
        case (op)
            OP_ADD:  w_base = op1 + op2;
            OP_SUB:  w_base = op1 - op2;
            OP_SLL:  w_base = op1 << w_shamt;
            OP_SLT:  w_base = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
            OP_SLTU: w_base = {{(WIDTH-1){1'b0}}, (op1 < op2)};
            OP_XOR:  w_base = op1 ^ op2;
            OP_SRL:  w_base = op1 >> w_shamt;
            OP_SRA:  w_base = $signed(op1) >>> w_shamt;
            OP_OR:   w_base = op1 | op2;
            OP_AND:  w_base = op1 & op2;
`ifdef ALU_MDU_DIV_EN
            OP_DIV, OP_DIVU: w_base = '1;
            OP_REM, OP_REMU: w_base = op1;
`endif
            default: w_base = c_magic;
        endcase
    end

    mdu_iter #(
        .WIDTH (WIDTH)
    ) u_mdu_iter (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_to_calc),
        .op    (op),
        .op1   (op1),
        .op2   (op2),
        .done  (w_mdu_done),
        .res   (w_mdu_res)
    );

    // Control FSM with registered handshake flags and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_to_calc) begin
                        r_state    <= ST_CALC;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else if (w_accept) begin
                        r_state     <= ST_DONE;
                        r_result    <= w_base;
                        r_zero      <= (w_base == '0);
                        r_in_ready  <= 1'b0;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_CALC: begin
                    if (w_mdu_done) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    r_state     <= ST_DONE;
                    r_result    <= w_mdu_res;
                    r_zero      <= (w_mdu_res == '0);
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign result    = r_result;
    assign zero      = r_zero;
    assign out_valid = r_out_valid;
    assign in_ready  = r_in_ready;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_alu_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mdu
//  Description : Directed self-checking bench for alu_mdu (WIDTH=32). A
//                reference model computes results with plain 64-bit
//                arithmetic; a monitor compares every DONE cycle against it,
//                and each vector also carries a hand-computed result/latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int          vectors;
    int          misses;
    logic [31:0] exp_res;
    logic        exp_pending;

    alu_mdu #(
        .WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            misses++;
            $display("FAIL %s: got %h, want %h", name, act, req);
        end
    endtask

    // Reference results from the architectural definition of each opcode
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        longint      ps;
        logic [63:0] pu;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (o)
            OP_ADD:    return a + b;
            OP_SUB:    return a - b;
            OP_SLL:    return a << b[4:0];
            OP_SLT:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_SLTU:   return (a < b) ? 32'd1 : 32'd0;
            OP_XOR:    return a ^ b;
            OP_SRL:    return a >> b[4:0];
            OP_SRA:    return 32'($signed(a) >>> b[4:0]);
            OP_OR:     return a | b;
            OP_AND:    return a & b;
            OP_MUL:    begin ps = sa * sb; return ps[31:0];  end
            OP_MULH:   begin ps = sa * sb; return ps[63:32]; end
            OP_MULHSU: begin ps = sa * ub; return ps[63:32]; end
            OP_MULHU:  begin pu = {32'd0, a} * {32'd0, b}; return pu[63:32]; end
`ifdef ALU_MDU_DIV_EN
            OP_DIV:    begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                ps = sa / sb;
                return ps[31:0];
            end
            OP_DIVU:   return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_REM:    begin
                if (b == 32'd0) return a;
                ps = sa % sb;
                return ps[31:0];
            end
            OP_REMU:   return (b == 32'd0) ? a : a % b;
`endif
            default:   return 32'h0000_DEAA;
        endcase
    endfunction

    // Monitor: whenever a result is presented it must match the model
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (!exp_pending) begin
                check("stray_out_valid", 32'(out_valid), 32'd0);
            end else begin
                check("mon_result", result, exp_res);
                check("mon_zero", 32'(zero), 32'(exp_res == 32'd0));
                check("mon_in_ready", 32'(in_ready), 32'd0);
            end
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check({name, "_ready_timeout"}, 32'(in_ready), 32'd1);
    endtask

    // Issue one op, check latency, busy span and hand-computed result;
    // optionally hold out_ready low for 'hold' cycles in DONE
    task automatic run_op(input string name, input logic [4:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit, input int lat, input int hold);
        int n;
        int nb;
        @(negedge clk);
        wait_ready(name);
        out_ready   = (hold == 0);
        op          = o;
        op1         = a;
        op2         = b;
        in_valid    = 1'b1;
        exp_res     = model(o, a, b);
        exp_pending = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        op1      = $urandom;
        op2      = $urandom;
        n  = 1;
        nb = 0;
        while (!out_valid && n < 100) begin
            if (busy) nb++;
            @(negedge clk);
            n++;
        end
        check({name, "_result"}, result, lit);
        check({name, "_latency"}, 32'(n), 32'(lat));
        check({name, "_busy_cycles"}, 32'(nb), 32'(lat - 1));
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                op       = OP_ADD;
                op1      = 32'd100;
                op2      = 32'd200;
                in_valid = 1'b1;
                check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
                check({name, "_hold_result"}, result, lit);
                @(negedge clk);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            check({name, "_release_out_valid"}, 32'(out_valid), 32'd0);
            check({name, "_release_in_ready"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors     = 0;
        misses      = 0;
        exp_pending = 1'b0;
        exp_res     = 32'd0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        op          = 5'd0;
        op1         = 32'd0;
        op2         = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_result", result, 32'd0);
        check("rst_zero", 32'(zero), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Base ops: 1-cycle latency
        run_op("add",   OP_ADD,  32'd5,         32'd3,         32'd8,          1, 0);
        run_op("sub",   OP_SUB,  32'd7,         32'd7,         32'd0,          1, 0);
        run_op("slt",   OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,          1, 0);
        run_op("sltu",  OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,          1, 0);
        run_op("sra",   OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000,  1, 0);
        run_op("srl",   OP_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000,  1, 0);
        run_op("sll",   OP_SLL,  32'd1,         32'h0000_0021, 32'd2,          1, 0);
        run_op("xor",   OP_XOR,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0,  1, 0);
        run_op("or",    OP_OR,   32'h1234_0000, 32'h0000_5678, 32'h1234_5678,  1, 0);
        run_op("and",   OP_AND,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0F00_0F00,  1, 0);
        run_op("ill1f", 5'b11111, 32'd1,        32'd2,         32'h0000_DEAA,  1, 0);
        run_op("ill18", 5'b11000, 32'd1,        32'd2,         32'h0000_DEAA,  1, 0);

        // Multiply: WIDTH+2 latency
        run_op("mul",    OP_MUL,    32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 34, 0);
        run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 34, 0);
        run_op("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34, 0);
        run_op("mul2",   OP_MUL,    32'd40000,     32'd70000, 32'hA6E4_9C00, 34, 0);
        run_op("mulhu2", OP_MULHU,  32'd40000,     32'd70000, 32'h0000_0000, 34, 0);

`ifdef ALU_MDU_DIV_EN
        run_op("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 0);
        run_op("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0);
        run_op("div_neg",  OP_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34, 0);
        run_op("rem_neg",  OP_REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34, 0);
        run_op("divu",     OP_DIVU, 32'd100,       32'd7,         32'd14,        34, 0);
        run_op("remu",     OP_REMU, 32'd100,       32'd7,         32'd2,         34, 0);
        run_op("divu_z",   OP_DIVU, 32'd5,         32'd0,         32'hFFFF_FFFF,  1, 0);
        run_op("remu_z",   OP_REMU, 32'd5,         32'd0,         32'd5,          1, 0);
        run_op("div_z",    OP_DIV,  32'd5,         32'd0,         32'hFFFF_FFFF,  1, 0);
        run_op("rem_z",    OP_REM,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9,  1, 0);
`else
        run_op("div_ill",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_DEAA,  1, 0);
        run_op("rem_ill",  OP_REM,  32'hFFFF_FFF9, 32'd2,         32'h0000_DEAA,  1, 0);
        run_op("divu_ill", OP_DIVU, 32'd5,         32'd0,         32'h0000_DEAA,  1, 0);
        run_op("remu_ill", OP_REMU, 32'd100,       32'd7,         32'h0000_DEAA,  1, 0);
`endif

        // Backpressure: result held, new requests ignored
        run_op("bp_add", OP_ADD, 32'd2, 32'd3, 32'd5, 1, 5);

        // Asynchronous reset in the middle of a multiply
        @(negedge clk);
        wait_ready("rst_mul");
        op          = OP_MUL;
        op1         = 32'd3;
        op2         = 32'd5;
        in_valid    = 1'b1;
        exp_res     = model(OP_MUL, 32'd3, 32'd5);
        exp_pending = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_zero", 32'(zero), 32'd0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        exp_pending = 1'b0;
        rst_n       = 1'b1;
        repeat (40) @(negedge clk);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        run_op("add_after_rst", OP_ADD, 32'd1, 32'd1, 32'd2, 1, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end

endmodule
`default_nettype wire
